// File: rtl/hdlc_pkg.sv
// Shared HDLC constants and receiver state type, imported by the frame transmitter and receiver.
package hdlc_pkg;

    localparam logic [7:0]  HDLC_FLAG         = 8'h7E;
    localparam int unsigned HDLC_FRAME_BITS   = 64;
    localparam logic [63:0] HDLC_IDLE_FRAME   = 64'h7E0001000037307E;

    // Bits that follow the opening flag: payload plus closing flag.
    localparam int unsigned HDLC_TAIL_BITS    = HDLC_FRAME_BITS - 8;
    localparam logic [5:0]  HDLC_LAST_CNT     = 6'(HDLC_TAIL_BITS - 1);

    typedef enum logic {
        HUNT,
        RECV
    } hdlc_rx_state_t;

endpackage

// File: rtl/hdlc_flag_detect.sv
// Combinational comparison of an 8-bit window against the HDLC flag byte.
module hdlc_flag_detect
    import hdlc_pkg::*;
(
    input  logic [7:0] window_i,
    output logic       match_o
);

    assign match_o = (window_i == HDLC_FLAG);

endmodule

// File: rtl/hdlc_recvdata.sv
// Serial HDLC 64-bit frame receiver: flag hunt, frame assembly, closing-flag check.
// Optional build macro HDLC_RECV_IDLE_FILTER_EN drops good frames equal to the idle frame.
module hdlc_recvdata
    import hdlc_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    output logic [HDLC_FRAME_BITS-1:0] data,
    output logic                       data_vld,
    output logic                       frame_err,
    output logic                       busy
);

    hdlc_rx_state_t             state_q, state_d;
    logic [HDLC_FRAME_BITS-1:0] sr_q, sr_d;
    logic [5:0]                 bit_cnt_q, bit_cnt_d;
    logic [HDLC_FRAME_BITS-1:0] data_q, data_d;
    logic                       data_vld_q, data_vld_d;
    logic                       frame_err_q, frame_err_d;

    logic [HDLC_FRAME_BITS-1:0] nxt;
    logic                       flag_hit;
    logic                       last_bit;
    logic                       drop_frame;

    assign nxt      = {sr_q[HDLC_FRAME_BITS-2:0], rx};
    assign last_bit = (state_q == RECV) && (bit_cnt_q == HDLC_LAST_CNT);

    // The same window serves as opening flag in HUNT and closing flag at the last bit.
    hdlc_flag_detect u_flag_detect (
        .window_i (nxt[7:0]),
        .match_o  (flag_hit)
    );

`ifdef HDLC_RECV_IDLE_FILTER_EN
    assign drop_frame = (nxt == HDLC_IDLE_FRAME);
`else
    assign drop_frame = 1'b0;
`endif

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            sr_q        <= '1;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            data_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            data_vld_q  <= data_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT: begin
                if (flag_hit) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (last_bit) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Datapath next values: shift register, bit counter, frame capture and pulses.
    always_comb begin
        sr_d        = nxt;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        data_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (flag_hit) begin
                    bit_cnt_d = '0;
                end
            end
            RECV: begin
                if (last_bit) begin
                    bit_cnt_d = '0;
                    if (flag_hit) begin
                        if (!drop_frame) begin
                            data_d     = nxt;
                            data_vld_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            default: bit_cnt_d = '0;
        endcase
    end

    // Outputs.
    always_comb begin
        busy      = (state_q == RECV);
        data      = data_q;
        data_vld  = data_vld_q;
        frame_err = frame_err_q;
    end

endmodule

// File: tb/tb_hdlc_recvdata.sv
// Self-checking bench for hdlc_recvdata: directed frames plus random traffic against a bit-history model.
module tb_hdlc_recvdata;

    localparam logic [63:0] IDLE_FRAME = 64'h7E0001000037307E;
`ifdef HDLC_RECV_IDLE_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [63:0] data;
    logic        data_vld;
    logic        frame_err;
    logic        busy;

    hdlc_recvdata dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .data_vld  (data_vld),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: history of line bits (ones before reset), hunt flag and bits since flag.
    bit          hist[$];
    bit          hunting;
    int          since;
    logic [63:0] m_data;
    logic        m_vld, m_err, m_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vld_cnt, err_cnt, busy_cnt, last_vld_cyc;

    function automatic logic [63:0] last64();
        logic [63:0] r;
        for (int k = 0; k < 64; k++) begin
            r[k] = (hist.size() > k) ? hist[hist.size() - 1 - k] : 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        hunting = 1'b1;
        since   = 0;
        m_data  = '0;
        m_vld   = 1'b0;
        m_err   = 1'b0;
        m_busy  = 1'b0;
    endtask

    task automatic model_step(input logic b);
        logic [63:0] w;
        m_vld = 1'b0;
        m_err = 1'b0;
        hist.push_back(b);
        if (hist.size() > 64) hist.delete(0);
        w = last64();
        if (hunting) begin
            if (w[7:0] == 8'h7E) begin
                hunting = 1'b0;
                since   = 0;
                m_busy  = 1'b1;
            end
        end else begin
            since++;
            if (since == 56) begin
                hunting = 1'b1;
                m_busy  = 1'b0;
                if (w[7:0] == 8'h7E) begin
                    if (!(FILTER && w == IDLE_FRAME)) begin
                        m_data = w;
                        m_vld  = 1'b1;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("data", data, m_data);
        check("data_vld", 64'(data_vld), 64'(m_vld));
        check("frame_err", 64'(frame_err), 64'(m_err));
        check("busy", 64'(busy), 64'(m_busy));
        if (data_vld === 1'b1) begin
            vld_cnt++;
            last_vld_cyc = cyc;
        end
        if (frame_err === 1'b1) err_cnt++;
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic clear_counts();
        vld_cnt  = 0;
        err_cnt  = 0;
        busy_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        @(posedge clk);
        cyc++;
        model_step(b);
        #1;
        compare_all();
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            cyc++;
            model_reset();
            #1;
            compare_all();
        end
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 63; i >= 0; i--) send_bit(f[i]);
    endtask

    function automatic logic [63:0] rand_frame(input bit good);
        logic [7:0] tail;
        tail = good ? 8'h7E : 8'($urandom_range(0, 255));
        if (tail == 8'h7E && !good) tail = 8'h7F;
        return {8'h7E, 32'($urandom), 16'($urandom), tail};
    endfunction

    initial begin
        logic [63:0] f1, f2, g;
        int          c1;
        model_reset();
        clear_counts();
        last_vld_cyc = 0;

        // Reset state.
        reset_cycles(2);

        // Continuous-high line never opens a frame.
        clear_counts();
        repeat (200) send_bit(1'b1);
        check("idle_vld_cnt", 64'(vld_cnt), 64'd0);
        check("idle_err_cnt", 64'(err_cnt), 64'd0);
        check("idle_busy_cnt", 64'(busy_cnt), 64'd0);
        check("idle_data", data, 64'h0);

        // Single good frame.
        clear_counts();
        send_bit(1'b1);
        send_frame(64'h7E12345678ABCD7E);
        check("good_vld_latency", 64'(last_vld_cyc), 64'(cyc));
        send_bit(1'b1);
        check("good_vld_cnt", 64'(vld_cnt), 64'd1);
        check("good_busy_cnt", 64'(busy_cnt), 64'd56);
        check("good_data", data, 64'h7E12345678ABCD7E);

        // Bad closing flag: error pulse, data held.
        clear_counts();
        send_bit(1'b1);
        send_frame(64'h7E11111111111100);
        repeat (3) send_bit(1'b1);
        check("bad_err_cnt", 64'(err_cnt), 64'd1);
        check("bad_vld_cnt", 64'(vld_cnt), 64'd0);
        check("bad_data_held", data, 64'h7E12345678ABCD7E);
        check("bad_back_to_hunt", 64'(busy), 64'd0);

        // Back-to-back good frames, 65 clk apart.
        clear_counts();
        f1 = rand_frame(1'b1);
        f2 = rand_frame(1'b1);
        send_bit(1'b1);
        send_frame(f1);
        c1 = last_vld_cyc;
        check("b2b_data1", data, f1);
        send_bit(1'b1);
        send_frame(f2);
        check("b2b_vld_cnt", 64'(vld_cnt), 64'd2);
        check("b2b_spacing", 64'(last_vld_cyc - c1), 64'd65);
        check("b2b_data2", data, f2);

        // Reset mid-frame, then a fresh frame.
        clear_counts();
        g = rand_frame(1'b1);
        send_bit(1'b1);
        for (int i = 63; i >= 34; i--) send_bit(f1[i]);
        reset_cycles(1);
        send_bit(1'b1);
        send_frame(g);
        check("rst_vld_cnt", 64'(vld_cnt), 64'd1);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_data", data, g);

        // Idle frame: filtered or delivered depending on build.
        clear_counts();
        send_bit(1'b1);
        send_frame(IDLE_FRAME);
        send_bit(1'b1);
        check("idle_frame_vld_cnt", 64'(vld_cnt), FILTER ? 64'd0 : 64'd1);
        check("idle_frame_err_cnt", 64'(err_cnt), 64'd0);
        check("idle_frame_data", data, FILTER ? g : IDLE_FRAME);

        // Random frame traffic with random gaps and closing flags.
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(1, 3)) send_bit(1'b1);
            send_frame(rand_frame($urandom_range(0, 3) != 0));
        end

        // Raw random line noise, then a recovery reset and one good frame.
        repeat (400) send_bit(1'($urandom_range(0, 1)));
        reset_cycles(1);
        clear_counts();
        f1 = rand_frame(1'b1);
        send_bit(1'b1);
        send_frame(f1);
        check("final_vld_cnt", 64'(vld_cnt), 64'd1);
        check("final_data", data, f1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
